// File: rtl/camera_capture_window.sv
// camera_capture_window: crops, decimates and packs one whole frame per capture request into 8-bit buffer writes.
module camera_capture_window #(
    parameter int PIXEL_WIDTH   = 10,
    parameter int COORD_WIDTH   = 12,
    parameter int ADDRESS_WIDTH = 18,
    parameter int BUFFER_DEPTH  = 40000
) (
    input  logic                     clock_pixel_in,
    input  logic                     reset_pixel_in,
    input  logic [PIXEL_WIDTH-1:0]   pixel_red_data_in,
    input  logic [PIXEL_WIDTH-1:0]   pixel_green_data_in,
    input  logic [PIXEL_WIDTH-1:0]   pixel_blue_data_in,
    input  logic                     line_valid_in,
    input  logic                     frame_valid_in,
    input  logic [COORD_WIDTH-1:0]   x_start_in,
    input  logic [COORD_WIDTH-1:0]   x_end_in,
    input  logic [COORD_WIDTH-1:0]   y_start_in,
    input  logic [COORD_WIDTH-1:0]   y_end_in,
    input  logic [1:0]               decimation_in,
    input  logic [1:0]               format_in,
    input  logic                     capture_start_in,
    output logic                     capture_busy_out,
    output logic                     capture_done_out,
    output logic                     overflow_out,
    output logic [ADDRESS_WIDTH-1:0] bytes_written_out,
    output logic [ADDRESS_WIDTH-1:0] write_address_out,
    output logic [7:0]               write_data_out,
    output logic                     write_enable_out
);
    localparam int P = PIXEL_WIDTH;
    localparam int C = COORD_WIDTH;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_DRAIN = 2'd3;
    localparam logic [ADDRESS_WIDTH:0] DEPTH = (ADDRESS_WIDTH+1)'(BUFFER_DEPTH);
    logic [1:0]     r_state;
    logic           r_fv_d, r_lv_d;
    logic [C-1:0]   r_x, r_y, r_xs, r_xe, r_ys, r_ye;
    logic [1:0]     r_dec;
    logic           r_gray;
    logic           r_s1_sel;
    logic [7:0]     r_s1_byte;
    logic [C-1:0]   w_mask, w_dx, w_dy;
    logic           w_sel, w_full, w_wr;
    logic [P+1:0]   w_sum;
    logic [P+9:0]   w_sum_top;
    logic [7:0]     w_byte;
    always_comb begin
        w_mask    = (r_dec == 2'd1) ? C'(1) : (r_dec == 2'd2) ? C'(3) : '0;
        w_dx      = r_x - r_xs;
        w_dy      = r_y - r_ys;
        w_sel     = frame_valid_in && line_valid_in && r_x >= r_xs && r_x < r_xe &&
                    r_y >= r_ys && r_y < r_ye && (w_dx & w_mask) == '0 && (w_dy & w_mask) == '0;
        w_sum     = (P+2)'(pixel_red_data_in) + ((P+2)'(pixel_green_data_in) << 1) + (P+2)'(pixel_blue_data_in);
        // top eight bits of the sum, zero-padded below for narrow pixels
        w_sum_top = {w_sum, 8'd0} >> (P+2);
        w_byte    = r_gray ? w_sum_top[7:0] :
                    {pixel_red_data_in[P-1:P-3], pixel_green_data_in[P-1:P-3], pixel_blue_data_in[P-1:P-2]};
        w_full    = {1'b0, bytes_written_out} == DEPTH;
        w_wr      = r_s1_sel && !w_full;
        capture_busy_out = r_state != S_IDLE;
    end
    always_ff @(posedge clock_pixel_in or posedge reset_pixel_in) begin
        if (reset_pixel_in) begin
            r_state           <= S_IDLE;
            r_fv_d            <= 1'b0;
            r_lv_d            <= 1'b0;
            r_x               <= '0;
            r_y               <= '0;
            r_xs              <= '0;
            r_xe              <= '0;
            r_ys              <= '0;
            r_ye              <= '0;
            r_dec             <= '0;
            r_gray            <= 1'b0;
            r_s1_sel          <= 1'b0;
            r_s1_byte         <= '0;
            capture_done_out  <= 1'b0;
            overflow_out      <= 1'b0;
            bytes_written_out <= '0;
            write_address_out <= '0;
            write_data_out    <= '0;
            write_enable_out  <= 1'b0;
        end else begin
            r_fv_d           <= frame_valid_in;
            r_lv_d           <= line_valid_in;
            r_x              <= !line_valid_in ? '0 : (frame_valid_in && !(&r_x)) ? r_x + 1'b1 : r_x;
            r_y              <= !frame_valid_in ? '0 : (r_lv_d && !line_valid_in && !(&r_y)) ? r_y + 1'b1 : r_y;
            r_s1_sel         <= w_sel && r_state == S_CAPTURE;
            r_s1_byte        <= w_byte;
            write_enable_out <= w_wr;
            if (w_wr) begin
                write_address_out <= bytes_written_out;
                write_data_out    <= r_s1_byte;
                bytes_written_out <= bytes_written_out + 1'b1;
            end
            if (r_s1_sel && w_full)
                overflow_out <= 1'b1;
            case (r_state)
                S_IDLE: if (capture_start_in) begin
                    r_state           <= S_ARMED;
                    capture_done_out  <= 1'b0;
                    overflow_out      <= 1'b0;
                    bytes_written_out <= '0;
                    r_xs              <= x_start_in;
                    r_xe              <= x_end_in;
                    r_ys              <= y_start_in;
                    r_ye              <= y_end_in;
                    r_dec             <= decimation_in;
                    r_gray            <= format_in == 2'd1;
                end
                S_ARMED:   r_state <= (frame_valid_in && !r_fv_d) ? S_CAPTURE : S_ARMED;
                S_CAPTURE: r_state <= frame_valid_in ? S_CAPTURE : S_DRAIN;
                default: begin
                    r_state          <= S_IDLE;
                    capture_done_out <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_camera_capture_window.sv
// tb_camera_capture_window: scoreboard bench driving a full-size and a 10-byte-buffer instance with identical frames.
module tb_camera_capture_window;
    localparam int P = 10, C = 12, A = 18;
    typedef struct {int addr; int data; int t;} exp_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [P-1:0] r = '0, g = '0, b = '0;
    logic lv = 1'b0, fv = 1'b0, start = 1'b0;
    logic [C-1:0] xs = '0, xe = '0, ys = '0, ye = '0;
    logic [1:0] dec = '0, fmt = '0;
    logic busy0, done0, ov0, we0, busy1, done1, ov1, we1;
    logic [A-1:0] bw0, wa0, bw1, wa1;
    logic [7:0] wd0, wd1;
    int checks = 0, errors = 0, cyc = 0;
    exp_t q0[$], q1[$];
    bit m_busy = 0, m_armed = 0, m_done = 0, m_ov0 = 0, m_ov1 = 0, m_gray = 0;
    int m_cnt0 = 0, m_cnt1 = 0, m_xs, m_xe, m_ys, m_ye, m_step;
    int fix_r[2], fix_g[2], fix_b[2];

    camera_capture_window #(.PIXEL_WIDTH(P), .COORD_WIDTH(C), .ADDRESS_WIDTH(A), .BUFFER_DEPTH(40000)) dut0 (
        .clock_pixel_in(clk), .reset_pixel_in(rst), .pixel_red_data_in(r), .pixel_green_data_in(g),
        .pixel_blue_data_in(b), .line_valid_in(lv), .frame_valid_in(fv), .x_start_in(xs), .x_end_in(xe),
        .y_start_in(ys), .y_end_in(ye), .decimation_in(dec), .format_in(fmt), .capture_start_in(start),
        .capture_busy_out(busy0), .capture_done_out(done0), .overflow_out(ov0), .bytes_written_out(bw0),
        .write_address_out(wa0), .write_data_out(wd0), .write_enable_out(we0));
    camera_capture_window #(.PIXEL_WIDTH(P), .COORD_WIDTH(C), .ADDRESS_WIDTH(A), .BUFFER_DEPTH(10)) dut1 (
        .clock_pixel_in(clk), .reset_pixel_in(rst), .pixel_red_data_in(r), .pixel_green_data_in(g),
        .pixel_blue_data_in(b), .line_valid_in(lv), .frame_valid_in(fv), .x_start_in(xs), .x_end_in(xe),
        .y_start_in(ys), .y_end_in(ye), .decimation_in(dec), .format_in(fmt), .capture_start_in(start),
        .capture_busy_out(busy1), .capture_done_out(done1), .overflow_out(ov1), .bytes_written_out(bw1),
        .write_address_out(wa1), .write_data_out(wd1), .write_enable_out(we1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (we0) begin
            if (q0.size() == 0) check("dut0_unexpected_write", 1, 0);
            else begin
                e = q0.pop_front();
                check("dut0_addr", wa0, e.addr);
                check("dut0_data", wd0, e.data);
                check("dut0_latency_cycle", cyc, e.t);
            end
        end
        if (we1) begin
            if (q1.size() == 0) check("dut1_unexpected_write", 1, 0);
            else begin
                e = q1.pop_front();
                check("dut1_addr", wa1, e.addr);
                check("dut1_data", wd1, e.data);
                check("dut1_latency_cycle", cyc, e.t);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int x0, x1, y0, y1, d, f);
        xs = C'(x0); xe = C'(x1); ys = C'(y0); ye = C'(y1); dec = 2'(d); fmt = 2'(f);
    endtask

    task automatic model_start();
        if (!m_busy) begin
            m_busy = 1; m_armed = 1; m_done = 0;
            m_cnt0 = 0; m_cnt1 = 0; m_ov0 = 0; m_ov1 = 0;
            m_xs = int'(xs); m_xe = int'(xe); m_ys = int'(ys); m_ye = int'(ye);
            m_step = (dec == 2'd1) ? 2 : (dec == 2'd2) ? 4 : 1;
            m_gray = fmt == 2'd1;
        end
    endtask

    task automatic start_cap();
        tick(); start = 1'b1; model_start();
        tick(); start = 1'b0;
    endtask

    task automatic push(input int col, row, rv, gv, bv);
        exp_t e;
        int bytev;
        if (col >= m_xs && col < m_xe && row >= m_ys && row < m_ye &&
            (col - m_xs) % m_step == 0 && (row - m_ys) % m_step == 0) begin
            bytev = m_gray ? ((rv + 2 * gv + bv) >> (P - 6)) & 255
                           : ((rv >> (P - 3)) << 5) | ((gv >> (P - 3)) << 2) | (bv >> (P - 2));
            e.data = bytev; e.t = cyc + 2;
            if (m_cnt0 < 40000) begin e.addr = m_cnt0; q0.push_back(e); m_cnt0++; end
            else m_ov0 = 1;
            if (m_cnt1 < 10) begin e.addr = m_cnt1; q1.push_back(e); m_cnt1++; end
            else m_ov1 = 1;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_dut0_done"}, done0, m_done);
        check({tag, "_dut0_busy"}, busy0, m_busy);
        check({tag, "_dut0_overflow"}, ov0, m_ov0);
        check({tag, "_dut0_bytes"}, bw0, m_cnt0);
        check({tag, "_dut0_pending"}, q0.size(), 0);
        check({tag, "_dut1_done"}, done1, m_done);
        check({tag, "_dut1_overflow"}, ov1, m_ov1);
        check({tag, "_dut1_bytes"}, bw1, m_cnt1);
        check({tag, "_dut1_pending"}, q1.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dut0_outputs"}, {busy0, done0, ov0, we0, bw0, wa0, wd0}, 0);
        check({tag, "_dut1_outputs"}, {busy1, done1, ov1, we1, bw1, wa1, wd1}, 0);
    endtask

    // pat 0: random pixels; pat 1: fixed pixels alternating by column parity
    task automatic frame(input string tag, input int w, h, pat, srow, arow);
        bit cap, ab;
        int rv, gv, bv;
        ab = 0;
        tick(); fv = 1'b1; lv = 1'b0;
        cap = m_armed; m_armed = 0;
        for (int row = 0; row < h && !ab; row++) begin
            for (int col = 0; col < w; col++) begin
                tick(); lv = 1'b1;
                rv = pat != 0 ? fix_r[col % 2] : int'($urandom_range(0, 1023));
                gv = pat != 0 ? fix_g[col % 2] : int'($urandom_range(0, 1023));
                bv = pat != 0 ? fix_b[col % 2] : int'($urandom_range(0, 1023));
                r = P'(rv); g = P'(gv); b = P'(bv);
                if (cap) push(col, row, rv, gv, bv);
            end
            tick(); lv = 1'b0; start = row == srow;
            if (start) model_start();
            tick(); start = 1'b0;
            if (row == arow) begin
                tick(); #1 rst = 1'b1;
                #1 check_zero({tag, "_async_reset"});
                q0.delete(); q1.delete();
                m_busy = 0; m_armed = 0; m_done = 0; m_cnt0 = 0; m_cnt1 = 0; m_ov0 = 0; m_ov1 = 0;
                cap = 0; ab = 1; fv = 1'b0;
                tick(); rst = 1'b0;
            end
        end
        tick(); fv = 1'b0; lv = 1'b0;
        repeat (5) tick();
        if (cap) begin m_busy = 0; m_done = 1; end
        check_status(tag);
    endtask

    initial begin
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        fix_r = '{1023, 1023}; fix_g = '{0, 0}; fix_b = '{1023, 1023};
        cfg(2, 6, 1, 5, 0, 0);
        start_cap();
        check("armed_busy", busy0, 1);
        frame("rgb332_dec0", 8, 6, 1, -1, -1);
        check("rgb332_dec0_bytes_const", bw0, 16);
        check("rgb332_dec0_data_const", wd0, 8'hE3);
        check("full_dut1_bytes_const", bw1, 10);
        check("full_dut1_overflow_const", ov1, 1);
        cfg(2, 6, 1, 5, 1, 0);
        start_cap();
        frame("rgb332_dec1", 8, 6, 1, -1, -1);
        check("rgb332_dec1_bytes_const", bw0, 4);
        fix_r = '{400, 1023}; fix_g = '{200, 1023}; fix_b = '{0, 1023};
        cfg(0, 8, 0, 6, 0, 1);
        start_cap();
        frame("gray8", 8, 6, 1, -1, -1);
        cfg(1, 7, 0, 6, 2, 0);
        frame("midframe_start", 8, 6, 0, 2, -1);
        check("midframe_still_busy", busy0, 1);
        cfg(0, 3, 0, 3, 0, 1);
        frame("second_start_ignored", 8, 6, 0, 1, -1);
        cfg(5, 5, 0, 6, 0, 0);
        start_cap();
        frame("empty_window", 8, 6, 0, -1, -1);
        check("empty_window_done_const", done0, 1);
        cfg(0, 8, 0, 6, 0, 0);
        start_cap();
        frame("reset_mid_capture", 8, 6, 0, -1, 2);
        start_cap();
        frame("after_reset", 8, 6, 0, -1, -1);
        for (int i = 0; i < 10; i++) begin
            cfg($urandom_range(0, 13), $urandom_range(0, 13), $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom_range(0, 3), $urandom_range(0, 3));
            start_cap();
            cfg($urandom_range(0, 13), $urandom_range(0, 13), $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom_range(0, 3), $urandom_range(0, 3));
            frame("random", $urandom_range(1, 12), $urandom_range(1, 8), 0, -1, -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
